load_store_unit: RTL and testbench

//  Core-side initiator for the data-memory port: takes one load/store from the EX/MEM stage,

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_load_align.sv | 28 ++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 codes,
// FSM states, fault codes and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

  typedef enum logic [1:0] {
    FLT_NONE       = 2'b00,
    FLT_MISALIGNED = 2'b01,
    FLT_ILLEGAL    = 2'b10,
    FLT_TIMEOUT    = 2'b11
  } lsu_fault_e;

  // Illegal encodings outrank misalignment.
  function automatic lsu_fault_e check_op(
    input logic       load,
    input logic       store,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ill;
    logic mis;
    ill = (load == store)
        || (store && !(f3 inside {F3_B, F3_H, F3_W}))
        || (load && (f3 inside {3'b011, 3'b110, 3'b111}));
    mis = ((f3 == F3_H || f3 == F3_HU) && a[0])
        || (f3 == F3_W && a != 2'b00);
    if (ill)
      return FLT_ILLEGAL;
    if (mis)
      return FLT_MISALIGNED;
    return FLT_NONE;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the byte/half lane of a
// memory word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = word[{addr, 3'b000} +: 8];
    h      = addr[1] ? word[31:16] : word[15:0];
    result = word;
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_BU:   result = {24'h0, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_HU:   result = {16'h0, h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store in flight, byte
// enables for sub-word stores, aligned/extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic        cpu_load,
  input  logic        cpu_store,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic [1:0]  cpu_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  state, state_d;
  lsu_fault_e  chk, fault_q;
  logic        load_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] rdata_q;
  logic [31:0] aligned;
  logic [CW-1:0] cnt;
  logic        cnt_exp;
  logic [3:0]  be_d;
  logic [31:0] wd_d;

  assign chk     = check_op(cpu_load, cpu_store,
                            cpu_funct3, cpu_addr[1:0]);
  assign cnt_exp = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:
        if (cpu_valid)
          state_d = (chk == FLT_NONE) ? REQ : DONE;
      REQ:
        if (mem_ack || cnt_exp)
          state_d = DONE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Stores replicate the data across lanes; BE selects.
  always_comb begin
    be_d = 4'b1111;
    wd_d = cpu_store ? cpu_wdata : 32'h0;
    if (cpu_store) begin
      case (cpu_funct3)
        F3_B: begin
          be_d = 4'b0001 << cpu_addr[1:0];
          wd_d = {4{cpu_wdata[7:0]}};
        end
        F3_H: begin
          be_d = 4'b0011 << {cpu_addr[1], 1'b0};
          wd_d = {2{cpu_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  lsu_load_align u_align (
    .word   (mem_rdata),
    .addr   (lane_q),
    .funct3 (f3_q),
    .result (aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q   <= FLT_NONE;
      load_q    <= 1'b0;
      f3_q      <= 3'b000;
      lane_q    <= 2'b00;
      rdata_q   <= 32'h0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_valid) begin
            load_q  <= cpu_load;
            f3_q    <= cpu_funct3;
            lane_q  <= cpu_addr[1:0];
            fault_q <= chk;
            rdata_q <= 32'h0;
            cnt     <= '0;
            if (chk == FLT_NONE) begin
              mem_req   <= 1'b1;
              mem_we    <= cpu_store;
              mem_addr  <= {cpu_addr[31:2], 2'b00};
              mem_be    <= be_d;
              mem_wdata <= wd_d;
            end
          end
        end
        REQ: begin
          if (mem_ack || cnt_exp) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
          end
          // An ack on the expiry cycle still completes.
          if (mem_ack) begin
            fault_q <= FLT_NONE;
            rdata_q <= load_q ? aligned : 32'h0;
          end else if (cnt_exp) begin
            fault_q <= FLT_TIMEOUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_busy  = (state != IDLE);
  assign cpu_done  = (state == DONE);
  assign cpu_rdata = cpu_done ? rdata_q : 32'h0;
  assign cpu_fault = cpu_done ? fault_q : FLT_NONE;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table,
// result scoreboard, reset and back-to-back sequences.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid, cpu_load, cpu_store;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_busy, cpu_done;
  logic [31:0] cpu_rdata;
  logic [1:0]  cpu_fault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_valid  (cpu_valid),
    .cpu_load   (cpu_load),
    .cpu_store  (cpu_store),
    .cpu_funct3 (cpu_funct3),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_busy   (cpu_busy),
    .cpu_done   (cpu_done),
    .cpu_rdata  (cpu_rdata),
    .cpu_fault  (cpu_fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          delay;
    logic [1:0]  fault;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] mwdata;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (cpu_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got done want none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_rdata", cpu_rdata, e.rdata);
        chk("sb_fault", {30'h0, cpu_fault}, {30'h0, e.fault});
      end
    end
  end

  task automatic drive(input vec_t v);
    cpu_valid  = 1'b1;
    cpu_load   = v.ld;
    cpu_store  = v.st;
    cpu_funct3 = v.f3;
    cpu_addr   = v.addr;
    cpu_wdata  = v.wdata;
  endtask

  task automatic run(input vec_t v);
    logic early;
    early = (v.fault == 2'b01) || (v.fault == 2'b10);
    @(posedge clk); #1;
    drive(v);
    exp_q.push_back('{v.rdata, v.fault});
    @(posedge clk); #1;
    if (early) begin
      chk("early_done", {31'h0, cpu_done}, 32'd1);
      chk("early_req", {31'h0, mem_req}, 32'd0);
    end else begin
      for (int c = 0; c < TO; c++) begin
        chk("req", {31'h0, mem_req}, 32'd1);
        chk("addr", mem_addr, {v.addr[31:2], 2'b00});
        chk("be", {28'h0, mem_be}, {28'h0, v.be});
        chk("we", {31'h0, mem_we}, {31'h0, v.st});
        if (v.st)
          chk("wdata", mem_wdata, v.mwdata);
        if (c == v.delay) begin
          mem_ack   = 1'b1;
          mem_rdata = v.mrdata;
        end
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        if (c == v.delay)
          break;
      end
      chk("done", {31'h0, cpu_done}, 32'd1);
      chk("req_drop", {31'h0, mem_req}, 32'd0);
    end
    cpu_valid = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse", {31'h0, cpu_done}, 32'd0);
    chk("idle_busy", {31'h0, cpu_busy}, 32'd0);
    chk("rdata_zero", cpu_rdata, 32'h0);
  endtask

  function automatic vec_t mk(
    input logic ld, input logic st, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wd,
    input logic [31:0] mr, input int dl,
    input logic [1:0] flt, input logic [31:0] rd,
    input logic [3:0] be, input logic [31:0] mwd);
    vec_t v;
    v = '{ld, st, f3, addr, wd, mr, dl, flt, rd, be, mwd};
    return v;
  endfunction

  vec_t v;

  initial begin
    reset     = 1'b1;
    cpu_valid = 1'b0;
    cpu_load  = 1'b0;
    cpu_store = 1'b0;
    cpu_funct3 = 3'b000;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'hBAD0BAD0;

    // ld st f3 addr wdata mrdata delay fault rdata be mwdata
    vecs.push_back(mk(0,1,3'b010,32'h10,32'hDEADBEEF,0,0,
                      2'b00,0,4'hF,32'hDEADBEEF));
    vecs.push_back(mk(0,1,3'b000,32'h13,32'h000000A5,0,0,
                      2'b00,0,4'h8,32'hA5A5A5A5));
    vecs.push_back(mk(0,1,3'b001,32'h12,32'h00001234,0,0,
                      2'b00,0,4'hC,32'h12341234));
    vecs.push_back(mk(0,1,3'b000,32'h01,32'h1234567F,0,0,
                      2'b00,0,4'h2,32'h7F7F7F7F));
    vecs.push_back(mk(1,0,3'b000,32'h11,0,32'h12348000,0,
                      2'b00,32'hFFFFFF80,4'hF,0));
    vecs.push_back(mk(1,0,3'b100,32'h11,0,32'h12348000,0,
                      2'b00,32'h00000080,4'hF,0));
    vecs.push_back(mk(1,0,3'b001,32'h12,0,32'h80010000,0,
                      2'b00,32'hFFFF8001,4'hF,0));
    vecs.push_back(mk(1,0,3'b101,32'h12,0,32'h80010000,0,
                      2'b00,32'h00008001,4'hF,0));
    vecs.push_back(mk(1,0,3'b000,32'h03,0,32'h7F000000,0,
                      2'b00,32'h0000007F,4'hF,0));
    vecs.push_back(mk(1,0,3'b010,32'h22,0,0,0,
                      2'b01,0,4'h0,0));
    vecs.push_back(mk(0,1,3'b011,32'h12,32'h1234,0,0,
                      2'b10,0,4'h0,0));
    vecs.push_back(mk(1,1,3'b010,32'h20,0,0,0,
                      2'b10,0,4'h0,0));
    vecs.push_back(mk(0,1,3'b101,32'h01,0,0,0,
                      2'b10,0,4'h0,0));
    vecs.push_back(mk(1,0,3'b101,32'h21,0,0,0,
                      2'b01,0,4'h0,0));
    vecs.push_back(mk(1,0,3'b010,32'h24,0,32'hCAFEF00D,3,
                      2'b00,32'hCAFEF00D,4'hF,0));
    vecs.push_back(mk(1,0,3'b010,32'h28,0,32'h11111111,-1,
                      2'b11,0,4'hF,0));
    vecs.push_back(mk(0,1,3'b010,32'h40,32'h0BADF00D,0,1,
                      2'b00,0,4'hF,32'h0BADF00D));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, cpu_busy}, 32'd0);
    chk("rst_done", {31'h0, cpu_done}, 32'd0);
    chk("rst_req", {31'h0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    reset = 1'b0;

    foreach (vecs[i])
      run(vecs[i]);

    // Reset in the second REQ cycle aborts silently.
    v = mk(1,0,3'b010,32'h30,0,0,0,2'b00,0,4'hF,0);
    @(posedge clk); #1;
    drive(v);
    @(posedge clk); #1;
    chk("abort_req1", {31'h0, mem_req}, 32'd1);
    @(posedge clk); #1;
    chk("abort_req2", {31'h0, mem_req}, 32'd1);
    reset     = 1'b1;
    cpu_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_req", {31'h0, mem_req}, 32'd0);
    chk("abort_busy", {31'h0, cpu_busy}, 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    run(mk(1,0,3'b010,32'h30,0,32'h55AA55AA,0,
           2'b00,32'h55AA55AA,4'hF,0));

    // A request still held during DONE waits one IDLE cycle.
    v = mk(1,0,3'b001,32'h46,0,32'hF00F0000,0,
           2'b00,32'hFFFFF00F,4'hF,0);
    @(posedge clk); #1;
    drive(v);
    exp_q.push_back('{v.rdata, v.fault});
    exp_q.push_back('{v.rdata, v.fault});
    @(posedge clk); #1;
    mem_ack   = 1'b1;
    mem_rdata = v.mrdata;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("b2b_done1", {31'h0, cpu_done}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_idle", {31'h0, cpu_busy}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_req", {31'h0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    cpu_valid = 1'b0;
    chk("b2b_done2", {31'h0, cpu_done}, 32'd1);
    repeat (3) @(posedge clk);
    #1;

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
